// File: rtl/icache_lookup_pe.sv
// -----------------------------------------------------------------------------
// icache_lookup_pe
//
// Per-PE instruction-cache lookup stage. Accepts fetch requests from one PE
// core, reads the N-way tag/data arrays (1-cycle read latency), and returns the
// addressed 32-bit instruction on a hit. On a miss it pulses a miss request
// with the fetch address and a one-hot victim way. It then waits for the
// shared updater's response and replays the lookup.
//
// Build option:
//   ICACHE_INVALID_FIRST_EN - when defined, a miss picks the lowest-numbered
//                             invalid way of the set, if any, and leaves the
//                             round-robin pointer untouched. When undefined,
//                             the victim is always the round-robin pointer.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req, i_addr    fetch request / address from the core
//   o_gnt            request accepted this cycle (combinational)
//   o_rvalid,o_rdata instruction return (one-cycle pulse, data held)
//   o_tag_rden       tag/data array read enable (combinational)
//   o_tag_addr       array set index (combinational)
//   i_tag_rdata      N_WAY tag entries {valid, tag}, 1 cycle after read
//   i_data_rdata     N_WAY cache lines, 1 cycle after read
//   o_cache_miss     miss request, one-cycle pulse
//   o_addr_miss      missing fetch address, held until the next miss
//   o_vic_miss       one-hot victim way, held until the next miss
//   i_resp_miss      refill-complete pulse from the updater
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module icache_lookup_pe #(
    parameter int ADDR_WIDTH = 6,
    parameter int TAG_WIDTH  = 8,
    parameter int DATA_WIDTH = 128,
    parameter int N_WAY      = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_req,
    input  logic [31:0]                   i_addr,
    output logic                          o_gnt,
    output logic                          o_rvalid,
    output logic [31:0]                   o_rdata,
    output logic                          o_tag_rden,
    output logic [ADDR_WIDTH-1:0]         o_tag_addr,
    input  logic [N_WAY*TAG_WIDTH-1:0]    i_tag_rdata,
    input  logic [N_WAY*DATA_WIDTH-1:0]   i_data_rdata,
    output logic                          o_cache_miss,
    output logic [31:0]                   o_addr_miss,
    output logic [N_WAY-1:0]              o_vic_miss,
    input  logic                          i_resp_miss
);

    localparam int TAG_LSB  = 2 + ADDR_WIDTH;
    localparam int TAG_BITS = TAG_WIDTH - 1;
    localparam int N_WORDS  = DATA_WIDTH / 32;
    localparam logic [N_WAY-1:0] VIC_RESET = N_WAY'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS,
        ST_WAIT_RESP,
        ST_REPLAY
    } state_t;

    state_t            r_state;
    logic [31:0]       r_addr;
    logic [N_WAY-1:0]  r_vic_ptr;

    logic [N_WAY-1:0]      w_hit_vec;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_line;
    logic [31:0]           w_word;
    logic [N_WAY-1:0]      w_victim;
    logic                  w_ptr_adv;
    logic                  w_gnt;

    // Tag compare and hit-way data select.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_hit_vec = '0;
        w_line    = '0;
        w_word    = '0;
        for (int k = 0; k < N_WAY; k++) begin
            w_hit_vec[k] = i_tag_rdata[k*TAG_WIDTH + TAG_WIDTH-1]
                         & (i_tag_rdata[k*TAG_WIDTH +: TAG_BITS] == r_addr[TAG_LSB +: TAG_BITS]);
        end
        // Descending scan: the lowest-numbered hitting way is written last and
        // wins if more than one way (illegally) hits.
        for (int k = N_WAY-1; k >= 0; k--) begin
            if (w_hit_vec[k]) begin
                w_line = i_data_rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int j = 0; j < N_WORDS; j++) begin
            if (r_addr[3:2] == 2'(j)) begin
                w_word = w_line[j*32 +: 32];
            end
        end
        w_hit = |w_hit_vec;
    end

    // Victim selection for the current lookup.
`ifdef ICACHE_INVALID_FIRST_EN
    logic [N_WAY-1:0] w_inv_onehot;
    logic             w_any_inv;

    always_comb begin
        w_inv_onehot = '0;
        w_any_inv    = 1'b0;
        for (int k = N_WAY-1; k >= 0; k--) begin
            if (!i_tag_rdata[k*TAG_WIDTH + TAG_WIDTH-1]) begin
                w_inv_onehot    = '0;
                w_inv_onehot[k] = 1'b1;
                w_any_inv       = 1'b1;
            end
        end
        w_victim  = w_any_inv ? w_inv_onehot : r_vic_ptr;
        w_ptr_adv = ~w_any_inv;
    end
`else
    always_comb begin
        w_victim  = r_vic_ptr;
        w_ptr_adv = 1'b1;
    end
`endif

    // Grant and array read port: a new request is taken from IDLE, or
    // pipelined behind a hitting lookup to sustain one fetch per cycle.
    always_comb begin
        w_gnt      = i_req & ((r_state == ST_IDLE) | ((r_state == ST_LOOKUP) & w_hit));
        o_gnt      = w_gnt;
        o_tag_rden = w_gnt | (r_state == ST_REPLAY);
        o_tag_addr = '0;
        if (w_gnt) begin
            o_tag_addr = i_addr[2 +: ADDR_WIDTH];
        end else if (r_state == ST_REPLAY) begin
            o_tag_addr = r_addr[2 +: ADDR_WIDTH];
        end
    end

    // Control FSM with registered outputs.
    // NOTE: state and registered outputs use non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_vic_ptr    <= VIC_RESET;
            o_rvalid     <= 1'b0;
            o_rdata      <= '0;
            o_cache_miss <= 1'b0;
            o_addr_miss  <= '0;
            o_vic_miss   <= VIC_RESET;
        end else begin
            o_rvalid     <= 1'b0;
            o_cache_miss <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_gnt) begin
                        r_addr  <= i_addr;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        o_rdata  <= w_word;
                        o_rvalid <= 1'b1;
                        if (w_gnt) begin
                            r_addr  <= i_addr;
                            r_state <= ST_LOOKUP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        // The miss request is registered on entry to MISS so
                        // the pulse, address and victim appear together while
                        // the FSM sits in MISS. Valid bits are only on the
                        // array bus now, so the victim is chosen here.
                        o_cache_miss <= 1'b1;
                        o_addr_miss  <= r_addr;
                        o_vic_miss   <= w_victim;
                        if (w_ptr_adv) begin
                            r_vic_ptr <= {r_vic_ptr[N_WAY-2:0], r_vic_ptr[N_WAY-1]};
                        end
                        r_state <= ST_MISS;
                    end
                end
                ST_MISS: begin
                    r_state <= ST_WAIT_RESP;
                end
                ST_WAIT_RESP: begin
                    // o_addr_miss / o_vic_miss hold here; the updater samples
                    // them more than once before responding.
                    if (i_resp_miss) begin
                        r_state <= ST_REPLAY;
                    end
                end
                ST_REPLAY: begin
                    r_state <= ST_LOOKUP;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_lookup_pe.sv
`timescale 1ns/1ps

module tb_icache_lookup_pe;

    localparam int AW = 6;
    localparam int TW = 8;
    localparam int DW = 128;
    localparam int NW = 4;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_req;
    logic [31:0]       i_addr;
    logic              o_gnt;
    logic              o_rvalid;
    logic [31:0]       o_rdata;
    logic              o_tag_rden;
    logic [AW-1:0]     o_tag_addr;
    logic [NW*TW-1:0]  i_tag_rdata;
    logic [NW*DW-1:0]  i_data_rdata;
    logic              o_cache_miss;
    logic [31:0]       o_addr_miss;
    logic [NW-1:0]     o_vic_miss;
    logic              i_resp_miss;

    icache_lookup_pe #(
        .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .N_WAY(NW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .o_gnt        (o_gnt),
        .o_rvalid     (o_rvalid),
        .o_rdata      (o_rdata),
        .o_tag_rden   (o_tag_rden),
        .o_tag_addr   (o_tag_addr),
        .i_tag_rdata  (i_tag_rdata),
        .i_data_rdata (i_data_rdata),
        .o_cache_miss (o_cache_miss),
        .o_addr_miss  (o_addr_miss),
        .o_vic_miss   (o_vic_miss),
        .i_resp_miss  (i_resp_miss)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // ---------------- array model (1-cycle read latency) ----------------
    logic [TW-1:0] tag_mem  [64][NW];
    logic [DW-1:0] data_mem [64][NW];

    always @(posedge i_clk) begin
        if (o_tag_rden) begin
            for (int k = 0; k < NW; k++) begin
                i_tag_rdata[k*TW +: TW]  <= tag_mem[o_tag_addr][k];
                i_data_rdata[k*DW +: DW] <= data_mem[o_tag_addr][k];
            end
        end
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    typedef struct { logic [31:0] data; int cyc; } rd_exp_t;
    typedef struct { logic [31:0] addr; logic [NW-1:0] vic; int cyc; } miss_exp_t;
    rd_exp_t   rd_q[$];
    miss_exp_t miss_q[$];

    // ---------------- reference model ----------------
    logic [NW-1:0] m_ptr = NW'(1);
    logic [NW-1:0] m_last_vic;
    logic [31:0]   cur_addr = '0;

    function automatic logic [DW-1:0] make_line(input int s, input int w, input logic [6:0] t);
        logic [DW-1:0] l;
        for (int j = 0; j < 4; j++) l[j*32 +: 32] = {4'hD, 4'(w), 1'b0, t, 8'(s), 8'(j)};
        return l;
    endfunction

    task automatic set_way(input int s, input int w, input logic v, input logic [6:0] t);
        tag_mem[s][w]  = {v, t};
        data_mem[s][w] = make_line(s, w, t);
    endtask

    function automatic int onehot_idx(input logic [NW-1:0] v);
        for (int w = 0; w < NW; w++) if (v[w]) return w;
        return 0;
    endfunction

    task automatic model_lookup(input logic [31:0] a, input int gc);
        int s = int'(a[7:2]);
        int wsel = int'(a[3:2]);
        int hw = -1;
        logic [NW-1:0] vic;
        for (int w = NW-1; w >= 0; w--)
            if (tag_mem[s][w][TW-1] && tag_mem[s][w][TW-2:0] == a[14:8]) hw = w;
        if (hw >= 0) begin
            rd_q.push_back('{data: data_mem[s][hw][wsel*32 +: 32], cyc: gc + 2});
        end else begin
            vic = m_ptr;
`ifdef ICACHE_INVALID_FIRST_EN
            begin
                int inv = -1;
                for (int w = NW-1; w >= 0; w--) if (!tag_mem[s][w][TW-1]) inv = w;
                if (inv >= 0) vic = NW'(1) << inv;
                else m_ptr = {m_ptr[NW-2:0], m_ptr[NW-1]};
            end
`else
            m_ptr = {m_ptr[NW-2:0], m_ptr[NW-1]};
`endif
            m_last_vic = vic;
            miss_q.push_back('{addr: a, vic: vic, cyc: gc + 2});
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge i_clk) begin : mon
        rd_exp_t   re;
        miss_exp_t me;
        if (i_rst_n) begin
            if (o_rvalid) begin
                if (rd_q.size() == 0) begin
                    check("rvalid_unexpected", 32'(o_rvalid), 32'd0);
                end else begin
                    re = rd_q.pop_front();
                    check("rdata", o_rdata, re.data);
                    check("rvalid_cycle", cyc, re.cyc);
                end
            end
            if (o_cache_miss) begin
                if (miss_q.size() == 0) begin
                    check("miss_unexpected", 32'(o_cache_miss), 32'd0);
                end else begin
                    me = miss_q.pop_front();
                    check("addr_miss", o_addr_miss, me.addr);
                    check("vic_miss", 32'(o_vic_miss), 32'(me.vic));
                    check("miss_cycle", cyc, me.cyc);
                end
            end
        end
    end

    // Illegal condition: more than one way hitting in a compare cycle.
    logic cmp_valid;
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cmp_valid <= 1'b0;
        else          cmp_valid <= o_tag_rden;
    end

    always @(negedge i_clk) begin : multi_hit
        logic [NW-1:0] hv;
        if (i_rst_n && cmp_valid) begin
            for (int k = 0; k < NW; k++)
                hv[k] = i_tag_rdata[k*TW + TW-1] && (i_tag_rdata[k*TW +: TW-1] == cur_addr[14:8]);
            assert ($onehot0(hv)) else $error("multiple ways hit for address 0x%08h", cur_addr);
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Present a request (called just after a rising edge); returns the
    // number of cycles spent waiting for o_gnt.
    task automatic issue(input logic [31:0] a, output int waits);
        int gc;
        waits  = 0;
        i_req  = 1'b1;
        i_addr = a;
        @(negedge i_clk);
        while (!o_gnt && waits < 50) begin
            waits++;
            @(negedge i_clk);
        end
        if (!o_gnt) check("gnt_timeout", 32'(o_gnt), 32'd1);
        gc = cyc;
        model_lookup(a, gc);
        @(posedge i_clk);
        cur_addr = a;
        #1;
        i_req = 1'b0;
    endtask

    // Plays the shared updater: waits for the miss pulse, holds for `delay`
    // cycles, writes the line into the model's victim way, then responds.
    task automatic refill(input logic [31:0] a, input int delay, output logic [NW-1:0] seen_vic);
        int n = 0;
        bit stable = 1'b1;
        logic [31:0] a_hold;
        int s = int'(a[7:2]);
        int wsel = int'(a[3:2]);
        int w;
        seen_vic = '0;
        @(negedge i_clk);
        while (!o_cache_miss && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_cache_miss) begin
            check("miss_timeout", 32'(o_cache_miss), 32'd1);
            return;
        end
        a_hold   = o_addr_miss;
        seen_vic = o_vic_miss;
        repeat (delay) begin
            @(negedge i_clk);
            if (o_addr_miss !== a_hold || o_vic_miss !== seen_vic) stable = 1'b0;
        end
        if (delay >= 20) check("miss_hold_stable", 32'(stable), 32'd1);
        w = onehot_idx(m_last_vic);
        set_way(s, w, 1'b1, a[14:8]);
        @(posedge i_clk);
        #1;
        i_resp_miss = 1'b1;
        rd_q.push_back('{data: data_mem[s][w][wsel*32 +: 32], cyc: cyc + 3});
        @(posedge i_clk);
        #1;
        i_resp_miss = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_gnt"},       32'(o_gnt),        32'd0);
        check({pfx, "_rvalid"},    32'(o_rvalid),     32'd0);
        check({pfx, "_rdata"},     o_rdata,           32'd0);
        check({pfx, "_tag_rden"},  32'(o_tag_rden),   32'd0);
        check({pfx, "_tag_addr"},  32'(o_tag_addr),   32'd0);
        check({pfx, "_cache_miss"},32'(o_cache_miss), 32'd0);
        check({pfx, "_addr_miss"}, o_addr_miss,       32'd0);
        check({pfx, "_vic_miss"},  32'(o_vic_miss),   32'd1);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        m_ptr   = NW'(1);
        rd_q.delete();
        miss_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int waits;
        logic [NW-1:0] v;
        logic [31:0] a;
        logic [NW-1:0] rr_tab [5];
        rr_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        for (int s = 0; s < 64; s++)
            for (int w = 0; w < NW; w++) set_way(s, w, 1'b0, 7'd0);
        i_rst_n     = 1'b0;
        i_req       = 1'b0;
        i_addr      = '0;
        i_resp_miss = 1'b0;

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("rst");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        idle(2);

        // Cold start miss and replay
        issue(32'h0000_0040, waits);
        check("cold_gnt_wait", waits, 0);
        refill(32'h0000_0040, 2, v);
        check("cold_vic", 32'(v), 32'h1);
        idle(6);

        // Back-to-back hits in way 2
        for (int s = 0; s < 4; s++) set_way(s, 2, 1'b1, 7'd1);
        for (int i = 0; i < 4; i++) begin
            issue(32'h100 + 32'(4*i), waits);
            check("b2b_gnt_wait", waits, 0);
        end
        idle(5);

        // Spurious refill responses in IDLE and in LOOKUP
        i_resp_miss = 1'b1;
        idle(1);
        i_resp_miss = 1'b0;
        idle(3);
        issue(32'h108, waits);
        check("idle_spur_gnt", waits, 0);
        i_resp_miss = 1'b1;
        idle(1);
        i_resp_miss = 1'b0;
        idle(4);
        issue(32'h10C, waits);
        check("lookup_spur_gnt", waits, 0);
        idle(5);

        // Set with way 1 invalid, then a fully valid set
        set_way(5, 0, 1'b1, 7'd10);
        set_way(5, 2, 1'b1, 7'd11);
        set_way(5, 3, 1'b1, 7'd12);
        issue(32'h0000_1414, waits);
        refill(32'h0000_1414, 2, v);
`ifdef ICACHE_INVALID_FIRST_EN
        check("invfirst_vic", 32'(v), 32'h2);
`endif
        idle(4);
        for (int w = 0; w < NW; w++) set_way(6, w, 1'b1, 7'(w + 1));
        issue(32'h0000_1418, waits);
        refill(32'h0000_1418, 2, v);
        idle(4);

        // Round-robin wrap: 5 misses into one fully valid set after reset
        do_reset();
        for (int w = 0; w < NW; w++) set_way(9, w, 1'b1, 7'(w + 1));
        for (int i = 0; i < 5; i++) begin
            a = (32'(30 + i) << 8) | (32'd9 << 2);
            issue(a, waits);
            refill(a, (i == 2) ? 20 : 2, v);
            check("rr_vic", 32'(v), 32'(rr_tab[i]));
            idle(4);
        end

        // Reset during WAIT_RESP
        a = 32'h0000_2830;
        issue(a, waits);
        waits = 0;
        @(negedge i_clk);
        while (!o_cache_miss && waits < 20) begin
            @(negedge i_clk);
            waits++;
        end
        check("wr_miss_seen", 32'(o_cache_miss), 32'd1);
        repeat (3) @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        m_ptr   = NW'(1);
        #1;
        check_reset_outputs("midrst");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        set_way(12, 0, 1'b1, a[14:8]);
        idle(1);
        i_resp_miss = 1'b1;
        idle(1);
        i_resp_miss = 1'b0;
        idle(6);
        issue(a, waits);
        check("post_rst_gnt", waits, 0);
        idle(6);

        check("rd_q_empty", rd_q.size(), 0);
        check("miss_q_empty", miss_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
